// File: rtl/uart_rx_apb_bridge.sv
// UART receive to APB bridge.
// Deserialises 8N1 frames, packs bytes into N_AES-bit blocks and writes each
// block as NWORDS words through an APB master. The bus runs independently of
// the receiver, so a block can arrive while the previous one is still on the bus.
module uart_rx_apb_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NBYTES     = DATA_WIDTH / 8,
    parameter int N_AES      = 128,
    parameter int NTICKS     = 16,
    parameter int MAX_BLOCKS = 4
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  en,
    input  logic [10:0]           divisor,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  rx,
    output logic                  PSELx,
    output logic                  PENABLE,
    output logic                  PWRITE,
    output logic [NBYTES-1:0]     PSTRB,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PREADY,
    output logic [N_AES-1:0]      block_data,
    output logic                  block_valid,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int NWORDS    = N_AES / DATA_WIDTH;
    localparam int BLK_BYTES = N_AES / 8;
    localparam int SW        = $clog2(NTICKS);
    localparam int BCW       = $clog2(BLK_BYTES);
    localparam int WW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int IW        = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {AP_IDLE, AP_SETUP, AP_ACCESS} apb_state_t;

    logic rx_meta, rx_s;
    logic [10:0] tick_cnt;
    logic tick;

    rx_state_t rx_state, rx_state_n;
    logic [SW-1:0] s_cnt, s_cnt_n;
    logic [2:0] n_cnt, n_cnt_n;
    logic [7:0] sh, sh_n;
    logic byte_done, ferr_n;

    logic [N_AES-1:0] asm_reg, full_blk, blk_src;
    logic [BCW-1:0] byte_cnt;
    logic last_byte, hold_free, handoff, apb_done;
    logic [IW-1:0] blk_idx, idx_inc, idx_cur;
    logic [ADDR_WIDTH-1:0] blk_base, new_base, base_src;

    apb_state_t apb_state, apb_n;
    logic [WW-1:0] word, word_n;
    logic [NWORDS-1:0][DATA_WIDTH-1:0] src_words;

    // Two-flop synchroniser; idles high like the line.
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end

    // Free-running oversample tick every divisor+1 cycles; >= tolerates divisor shrinking.
    assign tick = (tick_cnt >= divisor);
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) tick_cnt <= '0;
        else          tick_cnt <= tick ? 11'd0 : tick_cnt + 11'd1;

    // RX state register and bit/tick counters.
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            rx_state <= RX_IDLE;
            s_cnt    <= '0;
            n_cnt    <= '0;
            sh       <= '0;
        end else begin
            rx_state <= rx_state_n;
            s_cnt    <= s_cnt_n;
            n_cnt    <= n_cnt_n;
            sh       <= sh_n;
        end

    // RX next state: mid-start check, centre-of-bit sampling, stop-bit verdict.
    always_comb begin
        rx_state_n = rx_state;
        s_cnt_n    = s_cnt;
        n_cnt_n    = n_cnt;
        sh_n       = sh;
        byte_done  = 1'b0;
        ferr_n     = 1'b0;
        case (rx_state)
            RX_IDLE: if (!rx_s) begin
                rx_state_n = RX_START;
                s_cnt_n    = '0;
            end
            RX_START: if (tick) begin
                if (s_cnt == SW'(NTICKS/2 - 1)) begin
                    s_cnt_n    = '0;
                    n_cnt_n    = '0;
                    rx_state_n = rx_s ? RX_IDLE : RX_DATA;
                end else s_cnt_n = s_cnt + SW'(1);
            end
            RX_DATA: if (tick) begin
                if (s_cnt == SW'(NTICKS - 1)) begin
                    s_cnt_n = '0;
                    sh_n    = {rx_s, sh[7:1]};
                    if (n_cnt == 3'd7) rx_state_n = RX_STOP;
                    else               n_cnt_n    = n_cnt + 3'd1;
                end else s_cnt_n = s_cnt + SW'(1);
            end
            RX_STOP: if (tick) begin
                if (s_cnt == SW'(NTICKS - 1)) begin
                    byte_done  = rx_s;
                    ferr_n     = !rx_s;
                    rx_state_n = RX_IDLE;
                end else s_cnt_n = s_cnt + SW'(1);
            end
            default: rx_state_n = RX_IDLE;
        endcase
        if (!en) begin
            rx_state_n = RX_IDLE;
            byte_done  = 1'b0;
            ferr_n     = 1'b0;
        end
    end

    // Handoff decode. A buffer freeing this cycle counts as free.
    assign apb_done  = (apb_state == AP_ACCESS) && PREADY && (word == WW'(NWORDS - 1));
    assign hold_free = !busy || apb_done;
    assign full_blk  = {asm_reg[N_AES-9:0], sh};
    assign last_byte = byte_done && (byte_cnt == BCW'(BLK_BYTES - 1));
    assign handoff   = last_byte && hold_free;
    assign idx_inc   = (blk_idx == IW'(MAX_BLOCKS - 1)) ? '0 : blk_idx + IW'(1);
    assign idx_cur   = apb_done ? idx_inc : blk_idx;
    assign new_base  = start_addr + ADDR_WIDTH'(idx_cur) * ADDR_WIDTH'(BLK_BYTES);
    assign blk_src   = handoff ? full_blk : block_data;
    assign base_src  = handoff ? new_base : blk_base;
    assign src_words = blk_src;

    // Byte assembly, holding buffer (block_data) and status pulses.
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            asm_reg     <= '0;
            byte_cnt    <= '0;
            block_data  <= '0;
            block_valid <= 1'b0;
            frame_err   <= 1'b0;
            overrun     <= 1'b0;
            busy        <= 1'b0;
            blk_idx     <= '0;
            blk_base    <= '0;
        end else begin
            block_valid <= handoff;
            frame_err   <= ferr_n;
            overrun     <= last_byte && !hold_free;
            if (!en) byte_cnt <= '0;
            else if (byte_done) begin
                asm_reg  <= full_blk;
                byte_cnt <= last_byte ? '0 : byte_cnt + BCW'(1);
            end
            if (handoff) begin
                block_data <= full_blk;
                blk_base   <= new_base;
            end
            if (handoff)       busy <= 1'b1;
            else if (apb_done) busy <= 1'b0;
            if (apb_done) blk_idx <= idx_inc;
        end

    // APB state register.
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            apb_state <= AP_IDLE;
            word      <= '0;
        end else begin
            apb_state <= apb_n;
            word      <= word_n;
        end

    // APB next state: SETUP/ACCESS per word, back to back, no idle gaps.
    always_comb begin
        apb_n  = apb_state;
        word_n = word;
        case (apb_state)
            AP_IDLE: if (handoff) begin
                apb_n  = AP_SETUP;
                word_n = '0;
            end
            AP_SETUP: apb_n = AP_ACCESS;
            AP_ACCESS: if (PREADY) begin
                if (word == WW'(NWORDS - 1)) begin
                    apb_n  = handoff ? AP_SETUP : AP_IDLE;
                    word_n = '0;
                end else begin
                    apb_n  = AP_SETUP;
                    word_n = word + WW'(1);
                end
            end
            default: apb_n = AP_IDLE;
        endcase
    end

    // Registered bus outputs, computed from the next state so they align with it.
    always_ff @(posedge PCLK or negedge PRESETn)
        if (!PRESETn) begin
            PSELx   <= 1'b0;
            PENABLE <= 1'b0;
            PWRITE  <= 1'b0;
            PSTRB   <= '0;
            PADDR   <= '0;
            PWDATA  <= '0;
        end else begin
            PSELx   <= (apb_n != AP_IDLE);
            PENABLE <= (apb_n == AP_ACCESS);
            PWRITE  <= (apb_n != AP_IDLE);
            PSTRB   <= (apb_n != AP_IDLE) ? {NBYTES{1'b1}} : '0;
            PADDR   <= (apb_n != AP_IDLE) ? base_src + ADDR_WIDTH'(word_n) * ADDR_WIDTH'(NBYTES) : '0;
            PWDATA  <= (apb_n != AP_IDLE) ? src_words[WW'(NWORDS - 1) - word_n] : '0;
        end

endmodule

// File: tb/tb_uart_rx_apb_bridge.sv
// Bench for uart_rx_apb_bridge: UART byte driver, APB/pulse monitor,
// expected blocks and bus writes queued as bytes are sent.
module tb_uart_rx_apb_bridge;
    localparam int MAXB = 2;
    localparam logic [31:0] BASE = 32'h100;

    logic PCLK = 0, PRESETn = 0, en = 0, rx = 1, PREADY = 1;
    logic [10:0] divisor = 0;
    logic [31:0] start_addr = BASE;
    logic PSELx, PENABLE, PWRITE, block_valid, frame_err, overrun, busy;
    logic [3:0] PSTRB;
    logic [31:0] PADDR, PWDATA;
    logic [127:0] block_data;

    uart_rx_apb_bridge #(.MAX_BLOCKS(MAXB)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn), .en(en), .divisor(divisor),
        .start_addr(start_addr), .rx(rx), .PSELx(PSELx), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PSTRB(PSTRB), .PADDR(PADDR), .PWDATA(PWDATA),
        .PREADY(PREADY), .block_data(block_data), .block_valid(block_valid),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    always #5 PCLK = ~PCLK;

    logic [127:0] exp_blk_q[$], obs_blk_q[$];
    logic [31:0] exp_a_q[$], exp_d_q[$], obs_a_q[$], obs_d_q[$];
    int n_ferr = 0, n_ovr = 0, n_badctl = 0;
    int total = 0, bad = 0, exp_idx = 0;

    // Monitor: completed transfers, block pulses, flag pulses.
    always @(negedge PCLK) if (PRESETn) begin
        if (PSELx && PENABLE && PREADY) begin
            obs_a_q.push_back(PADDR);
            obs_d_q.push_back(PWDATA);
            if (PWRITE !== 1'b1 || PSTRB !== 4'hF) n_badctl++;
        end
        if (block_valid) obs_blk_q.push_back(block_data);
        if (frame_err) n_ferr++;
        if (overrun) n_ovr++;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge PCLK);
        #1;
    endtask

    task automatic do_reset();
        PRESETn = 0; en = 0; rx = 1;
        cyc(3);
        PRESETn = 1; en = 1;
        cyc(2);
        exp_blk_q.delete(); obs_blk_q.delete();
        exp_a_q.delete(); exp_d_q.delete(); obs_a_q.delete(); obs_d_q.delete();
        exp_idx = 0;
    endtask

    task automatic uart_byte(input logic [7:0] b, input bit good);
        int bc;
        bc = (int'(divisor) + 1) * 16;
        rx = 0; cyc(bc);
        for (int i = 0; i < 8; i++) begin rx = b[i]; cyc(bc); end
        if (good) begin rx = 1; cyc(bc); end
        else begin rx = 0; cyc(bc * 3 / 4); rx = 1; cyc(bc * 2 + bc / 4); end
    endtask

    task automatic expect_block(input logic [127:0] blk);
        exp_blk_q.push_back(blk);
        for (int k = 0; k < 4; k++) begin
            exp_a_q.push_back(start_addr + 32'(exp_idx * 16 + k * 4));
            exp_d_q.push_back(blk[127-32*k -: 32]);
        end
        exp_idx = (exp_idx + 1) % MAXB;
    endtask

    task automatic send_block(input logic [7:0] first, input bit want);
        logic [127:0] blk;
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(first + i);
        if (want) expect_block(blk);
        for (int i = 0; i < 16; i++) uart_byte(8'(first + i), 1'b1);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        cyc(8);
        while (busy && n < 3000) begin cyc(1); n++; end
        if (busy) begin total++; bad++; $display("FAIL %s busy timeout busy=%b want 0", name, busy); end
        cyc(2);
    endtask

    task automatic test_reset();
        PRESETn = 0; cyc(4);
        total++;
        if ({PSELx, PENABLE, PWRITE, PSTRB, PADDR, PWDATA} !== '0) begin
            bad++; $display("FAIL reset_bus got sel=%b en=%b addr=%h want 0", PSELx, PENABLE, PADDR);
        end
        total++;
        if ({block_data, block_valid, frame_err, overrun, busy} !== '0) begin
            bad++; $display("FAIL reset_status got blk=%h busy=%b want 0", block_data, busy);
        end
    endtask

    task automatic test_nominal();
        logic [127:0] e, g;
        logic [31:0] ea, ed, ga, gd;
        int f0, o0;
        divisor = 2; PREADY = 1; do_reset();
        f0 = n_ferr; o0 = n_ovr;
        send_block(8'h00, 1'b1);
        wait_idle("nominal");
        total++;
        if (exp_blk_q[0] !== 128'h000102030405060708090A0B0C0D0E0F) begin
            bad++; $display("FAIL nominal_model got=%h want=000102030405060708090a0b0c0d0e0f", exp_blk_q[0]);
        end
        while (exp_blk_q.size() > 0) begin
            e = exp_blk_q.pop_front(); g = 'x;
            if (obs_blk_q.size() > 0) g = obs_blk_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL nominal_block got=%h want=%h", g, e); end
        end
        while (exp_a_q.size() > 0) begin
            ea = exp_a_q.pop_front(); ed = exp_d_q.pop_front(); ga = 'x; gd = 'x;
            if (obs_a_q.size() > 0) begin ga = obs_a_q.pop_front(); gd = obs_d_q.pop_front(); end
            total++; if (ga !== ea || gd !== ed) begin bad++; $display("FAIL nominal_write got=%h@%h want=%h@%h", gd, ga, ed, ea); end
        end
        total++;
        if (obs_a_q.size() + obs_blk_q.size() != 0 || n_ferr != f0 || n_ovr != o0) begin
            bad++; $display("FAIL nominal_extra got extra=%0d ferr=%0d ovr=%0d want 0", obs_a_q.size() + obs_blk_q.size(), n_ferr - f0, n_ovr - o0);
        end
    endtask

    task automatic test_frame_err();
        logic [127:0] e, g;
        logic [31:0] ea, ed, ga, gd;
        int f0;
        divisor = 0; PREADY = 1; do_reset();
        f0 = n_ferr;
        uart_byte(8'hA5, 1'b0);
        total++;
        if (n_ferr - f0 != 1) begin bad++; $display("FAIL frame_err_count got=%0d want=1", n_ferr - f0); end
        send_block(8'h10, 1'b1);
        wait_idle("frame_err");
        while (exp_blk_q.size() > 0) begin
            e = exp_blk_q.pop_front(); g = 'x;
            if (obs_blk_q.size() > 0) g = obs_blk_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL frame_err_block got=%h want=%h", g, e); end
        end
        while (exp_a_q.size() > 0) begin
            ea = exp_a_q.pop_front(); ed = exp_d_q.pop_front(); ga = 'x; gd = 'x;
            if (obs_a_q.size() > 0) begin ga = obs_a_q.pop_front(); gd = obs_d_q.pop_front(); end
            total++; if (ga !== ea || gd !== ed) begin bad++; $display("FAIL frame_err_write got=%h@%h want=%h@%h", gd, ga, ed, ea); end
        end
        total++;
        if (n_ferr - f0 != 1 || obs_a_q.size() != 0) begin
            bad++; $display("FAIL frame_err_final got ferr=%0d extra=%0d want 1,0", n_ferr - f0, obs_a_q.size());
        end
    endtask

    task automatic test_glitch();
        logic [127:0] e, g;
        int f0;
        divisor = 2; PREADY = 1; do_reset();
        f0 = n_ferr;
        rx = 0; cyc(10); rx = 1; cyc(300);
        total++;
        if (n_ferr != f0 || obs_blk_q.size() != 0 || PSELx !== 1'b0) begin
            bad++; $display("FAIL glitch_flags got ferr=%0d blk=%0d sel=%b want 0", n_ferr - f0, obs_blk_q.size(), PSELx);
        end
        // A byte wrongly accepted from the glitch would shift this block.
        divisor = 0;
        send_block(8'h40, 1'b1);
        wait_idle("glitch");
        while (exp_blk_q.size() > 0) begin
            e = exp_blk_q.pop_front(); g = 'x;
            if (obs_blk_q.size() > 0) g = obs_blk_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL glitch_block got=%h want=%h", g, e); end
        end
        exp_a_q.delete(); exp_d_q.delete(); obs_a_q.delete(); obs_d_q.delete();
    endtask

    task automatic test_overrun();
        logic [127:0] e, g;
        logic [31:0] ea, ed, ga, gd;
        int o0;
        divisor = 0; PREADY = 0; do_reset();
        o0 = n_ovr;
        send_block(8'h20, 1'b1);
        for (int i = 0; i < 15; i++) uart_byte(8'(8'h30 + i), 1'b1);
        total++;
        if (n_ovr != o0) begin bad++; $display("FAIL overrun_early got=%0d want=0", n_ovr - o0); end
        uart_byte(8'h3F, 1'b1);
        cyc(4);
        total++;
        if (n_ovr - o0 != 1) begin bad++; $display("FAIL overrun_count got=%0d want=1", n_ovr - o0); end
        total++;
        if (busy !== 1'b1 || PSELx !== 1'b1 || PENABLE !== 1'b1 || PADDR !== BASE) begin
            bad++; $display("FAIL overrun_stall got busy=%b sel=%b en=%b addr=%h want 1,1,1,%h", busy, PSELx, PENABLE, PADDR, BASE);
        end
        PREADY = 1;
        wait_idle("overrun");
        while (exp_blk_q.size() > 0) begin
            e = exp_blk_q.pop_front(); g = 'x;
            if (obs_blk_q.size() > 0) g = obs_blk_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL overrun_block got=%h want=%h", g, e); end
        end
        while (exp_a_q.size() > 0) begin
            ea = exp_a_q.pop_front(); ed = exp_d_q.pop_front(); ga = 'x; gd = 'x;
            if (obs_a_q.size() > 0) begin ga = obs_a_q.pop_front(); gd = obs_d_q.pop_front(); end
            total++; if (ga !== ea || gd !== ed) begin bad++; $display("FAIL overrun_write got=%h@%h want=%h@%h", gd, ga, ed, ea); end
        end
        total++;
        if (obs_a_q.size() + obs_blk_q.size() != 0) begin
            bad++; $display("FAIL overrun_extra got=%0d want=0", obs_a_q.size() + obs_blk_q.size());
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ea, ed, ga, gd;
        logic [31:0] firsts [3];
        int b0;
        divisor = 0; PREADY = 1; do_reset();
        b0 = n_badctl;
        send_block(8'h60, 1'b1);
        send_block(8'h70, 1'b1);
        send_block(8'h80, 1'b1);
        wait_idle("wrap");
        exp_blk_q.delete(); obs_blk_q.delete();
        for (int n = 0; n < 12; n++) begin
            ea = exp_a_q.pop_front(); ed = exp_d_q.pop_front(); ga = 'x; gd = 'x;
            if (obs_a_q.size() > 0) begin ga = obs_a_q.pop_front(); gd = obs_d_q.pop_front(); end
            if (n % 4 == 0) firsts[n/4] = ga;
            total++; if (ga !== ea || gd !== ed) begin bad++; $display("FAIL wrap_write got=%h@%h want=%h@%h", gd, ga, ed, ea); end
        end
        total++;
        if (firsts[0] !== 32'h100 || firsts[1] !== 32'h110 || firsts[2] !== 32'h100) begin
            bad++; $display("FAIL wrap_bases got=%h,%h,%h want=100,110,100", firsts[0], firsts[1], firsts[2]);
        end
        total++;
        if (n_badctl != b0 || obs_a_q.size() != 0) begin
            bad++; $display("FAIL wrap_ctl got badctl=%0d extra=%0d want 0", n_badctl - b0, obs_a_q.size());
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] blk, e, g;
        logic [31:0] ea, ed, ga, gd;
        int n;
        divisor = 0; PREADY = 0; do_reset();
        for (int i = 0; i < 16; i++) blk[127-8*i -: 8] = 8'(8'h90 + i);
        exp_blk_q.push_back(blk);
        for (int k = 0; k < 2; k++) begin
            exp_a_q.push_back(BASE + 32'(k * 4));
            exp_d_q.push_back(blk[127-32*k -: 32]);
        end
        for (int i = 0; i < 16; i++) uart_byte(8'(8'h90 + i), 1'b1);
        cyc(4);
        PREADY = 1;
        n = 0;
        while (!(PSELx && !PENABLE && PADDR == BASE + 32'h8) && n < 50) begin @(negedge PCLK); n++; end
        total++;
        if (n >= 50) begin bad++; $display("FAIL reset_mid_word2 timeout addr=%h want %h", PADDR, BASE + 32'h8); end
        #2 PRESETn = 0;
        #1;
        total++;
        if ({PSELx, PENABLE, PWRITE, PSTRB, PADDR, PWDATA, block_data, busy} !== '0) begin
            bad++; $display("FAIL reset_mid_outputs got sel=%b addr=%h busy=%b want 0", PSELx, PADDR, busy);
        end
        cyc(3);
        PRESETn = 1;
        cyc(2);
        exp_idx = 0;
        while (exp_a_q.size() > 0) begin
            ea = exp_a_q.pop_front(); ed = exp_d_q.pop_front(); ga = 'x; gd = 'x;
            if (obs_a_q.size() > 0) begin ga = obs_a_q.pop_front(); gd = obs_d_q.pop_front(); end
            total++; if (ga !== ea || gd !== ed) begin bad++; $display("FAIL reset_mid_partial got=%h@%h want=%h@%h", gd, ga, ed, ea); end
        end
        total++;
        if (obs_a_q.size() != 0) begin bad++; $display("FAIL reset_mid_word2_written got extra=%0d want 0", obs_a_q.size()); end
        send_block(8'hC0, 1'b1);
        wait_idle("reset_mid");
        while (exp_blk_q.size() > 0) begin
            e = exp_blk_q.pop_front(); g = 'x;
            if (obs_blk_q.size() > 0) g = obs_blk_q.pop_front();
            total++; if (g !== e) begin bad++; $display("FAIL reset_mid_block got=%h want=%h", g, e); end
        end
        while (exp_a_q.size() > 0) begin
            ea = exp_a_q.pop_front(); ed = exp_d_q.pop_front(); ga = 'x; gd = 'x;
            if (obs_a_q.size() > 0) begin ga = obs_a_q.pop_front(); gd = obs_d_q.pop_front(); end
            total++; if (ga !== ea || gd !== ed) begin bad++; $display("FAIL reset_mid_write got=%h@%h want=%h@%h", gd, ga, ed, ea); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_frame_err();
        test_glitch();
        test_overrun();
        test_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
